control_loop_math_mc: RTL and testbench

//  Multi-channel successor of the single-channel PI math block: computes
//  adj = adj_prev + (P + I*dt)*e_cur - P*e_prev for one of CHANNELS loops per arm.
//  One shared sequential shift-add multiplier; per-channel e_prev/adj_prev held internally.

---
 rtl/control_loop_math_mc.sv | 248 ++++++++++++++++++++++++
 tb/tb_control_loop_math_mc.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_loop_math_mc.sv
// control_loop_math_mc
//   Multi-channel PI update engine. One update per arm computes
//     adj = adj_prev[ch] + (P + I*dt)*e_cur - P*e_prev[ch]
//   using a single shared sequential shift-add multiplier. The multiplier
//   retires one bit per cycle and is used three times per update: I*dt,
//   K*e_cur and P*e_prev. Each channel keeps its own e_prev and adj_prev.
//   The result is saturated to the adj_val format and clamped to the DAC
//   range. With ANTI_WINDUP=1 the clamped DAC code is stored as adj_prev.
//   Latency is 3*CONSTS_WID+2 cycles from the accepting edge to finished.
// Ports
//   clk, rst_L      clock and asynchronous active-low reset
//   arm             start request (level); finished is held while arm stays 1
//   ch_sel          channel to update (sampled on accept) or to clear
//   clr             in idle with arm=0: zero the history of channel ch_sel
//   setpt/measured  signed ADC words; e_cur = setpt - measured
//   cl_P/cl_I/dt    signed CONSTS_WHOLE.CONSTS_FRAC constants
//   busy            an update is in progress
//   finished        result valid; held until arm goes low
//   e_cur           error of the accepted update
//   adj_val         saturated adjustment, OUT_WHOLE.OUT_FRAC
//   dac_val         whole part of adj_val clamped to the DAC range
//   clamped         dac_val is not the exact result, because a saturation
//                   happened along the datapath or the DAC range was hit
module control_loop_math_mc #(
  parameter int CHANNELS     = 4,
  parameter int CONSTS_WHOLE = 8,
  parameter int CONSTS_FRAC  = 40,
  parameter int ADC_WID      = 18,
  parameter int DAC_DATA_WID = 20,
  parameter int OUT_WHOLE    = 20,
  parameter int OUT_FRAC     = 40,
  parameter int ANTI_WINDUP  = 1,
  localparam int CONSTS_WID  = CONSTS_WHOLE + CONSTS_FRAC,
  localparam int E_WID       = ADC_WID + 1,
  localparam int OUT_WID     = OUT_WHOLE + OUT_FRAC,
  localparam int CH_WID      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_L,
  input  logic                    arm,
  input  logic [CH_WID-1:0]       ch_sel,
  input  logic                    clr,
  input  logic [ADC_WID-1:0]      setpt,
  input  logic [ADC_WID-1:0]      measured,
  input  logic [CONSTS_WID-1:0]   cl_P,
  input  logic [CONSTS_WID-1:0]   cl_I,
  input  logic [CONSTS_WID-1:0]   dt,
  output logic                    busy,
  output logic                    finished,
  output logic [E_WID-1:0]        e_cur,
  output logic [OUT_WID-1:0]      adj_val,
  output logic [DAC_DATA_WID-1:0] dac_val,
  output logic                    clamped
);

  // Working width: holds any full product and the guarded adj sum exactly.
  localparam int PW    = 2 * CONSTS_WID;
  localparam int CNT_W = $clog2(CONSTS_WID);

  localparam logic signed [PW-1:0] ONE_W = PW'(1);
  localparam logic signed [PW-1:0] C_MAX = (ONE_W <<< (CONSTS_WID - 1)) - ONE_W;
  localparam logic signed [PW-1:0] C_MIN = ~C_MAX;
  localparam logic signed [PW-1:0] O_MAX = (ONE_W <<< (OUT_WID - 1)) - ONE_W;
  localparam logic signed [PW-1:0] O_MIN = ~O_MAX;
  localparam logic signed [PW-1:0] D_MAX = (ONE_W <<< (DAC_DATA_WID - 1)) - ONE_W;
  localparam logic signed [PW-1:0] D_MIN = ~D_MAX;

  typedef enum logic [2:0] {IDLE, MUL_IDT, MUL_EK, MUL_PE, SUM, DONE} state_t;

  function automatic logic [CONSTS_WID-1:0] sat_c(input logic signed [PW-1:0] v);
    if (v > C_MAX) return C_MAX[CONSTS_WID-1:0];
    if (v < C_MIN) return C_MIN[CONSTS_WID-1:0];
    return v[CONSTS_WID-1:0];
  endfunction

  function automatic logic [OUT_WID-1:0] sat_o(input logic signed [PW-1:0] v);
    if (v > O_MAX) return O_MAX[OUT_WID-1:0];
    if (v < O_MIN) return O_MIN[OUT_WID-1:0];
    return v[OUT_WID-1:0];
  endfunction

  function automatic logic [DAC_DATA_WID-1:0] sat_d(input logic signed [PW-1:0] v);
    if (v > D_MAX) return D_MAX[DAC_DATA_WID-1:0];
    if (v < D_MIN) return D_MIN[DAC_DATA_WID-1:0];
    return v[DAC_DATA_WID-1:0];
  endfunction

  state_t                       state;
  logic [CH_WID-1:0]            ch_r;
  logic signed [CONSTS_WID-1:0] p_r;
  logic signed [PW-1:0]         acc;
  logic signed [PW-1:0]         mcand;
  logic [CONSTS_WID-1:0]        mplier;
  logic [CNT_W-1:0]             cnt;
  logic signed [OUT_WID-1:0]    ek_r;
  logic signed [OUT_WID-1:0]    pe_r;
  logic signed [OUT_WID-1:0]    adj_r;
  logic                         sat_seen;
  logic signed [E_WID-1:0]      e_prev   [CHANNELS];
  logic signed [OUT_WID-1:0]    adj_prev [CHANNELS];

  logic                    last;
  logic signed [PW-1:0]    term, acc_nxt, idt_full, k_full, adj_full, whole_full;
  logic [CONSTS_WID-1:0]   idt_s, k_s;
  logic [OUT_WID-1:0]      prod_s, adj_s;
  logic [DAC_DATA_WID-1:0] dac_s;
  logic                    idt_ovf, k_ovf, prod_ovf, adj_ovf, dac_ovf;

  // NOTE: every signal gets a default before any conditional assignment so
  // that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    last = (cnt == CNT_W'(CONSTS_WID - 1));
    term = '0;
    // Two's complement: the top multiplier bit carries negative weight.
    if (mplier[0]) term = last ? -mcand : mcand;
    acc_nxt = acc + term;

    idt_full = acc_nxt >>> CONSTS_FRAC;
    idt_s    = sat_c(idt_full);
    idt_ovf  = (idt_full > C_MAX) || (idt_full < C_MIN);
    k_full   = PW'(p_r) + PW'($signed(idt_s));
    k_s      = sat_c(k_full);
    k_ovf    = (k_full > C_MAX) || (k_full < C_MIN);

    // e is an integer, so K*e and P*e_prev already sit at OUT_FRAC.
    prod_s   = sat_o(acc_nxt);
    prod_ovf = (acc_nxt > O_MAX) || (acc_nxt < O_MIN);

    adj_full = PW'(adj_prev[ch_r]) + PW'(ek_r) - PW'(pe_r);
    adj_s    = sat_o(adj_full);
    adj_ovf  = (adj_full > O_MAX) || (adj_full < O_MIN);

    whole_full = PW'($signed(adj_r[OUT_WID-1:OUT_FRAC]));
    dac_s      = sat_d(whole_full);
    dac_ovf    = (whole_full > D_MAX) || (whole_full < D_MIN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state    <= IDLE;
      ch_r     <= '0;
      p_r      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      ek_r     <= '0;
      pe_r     <= '0;
      adj_r    <= '0;
      sat_seen <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
      e_cur    <= '0;
      adj_val  <= '0;
      dac_val  <= '0;
      clamped  <= 1'b0;
      // NOTE: the channel history is deliberately reset: a loop must restart
      // from zero history after reset, so these stay flops, not a RAM.
      for (int i = 0; i < CHANNELS; i++) begin
        e_prev[i]   <= '0;
        adj_prev[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            ch_r     <= ch_sel;
            p_r      <= cl_P;
            mcand    <= PW'($signed(cl_I));
            mplier   <= dt;
            acc      <= '0;
            cnt      <= '0;
            sat_seen <= 1'b0;
            e_cur    <= {setpt[ADC_WID-1], setpt} - {measured[ADC_WID-1], measured};
            busy     <= 1'b1;
            state    <= MUL_IDT;
          end else if (clr) begin
            e_prev[ch_sel]   <= '0;
            adj_prev[ch_sel] <= '0;
          end
        end

        MUL_IDT, MUL_EK, MUL_PE: begin
          acc    <= acc_nxt;
          mcand  <= mcand <<< 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            // Product complete: consume it and load the next operand pair.
            acc <= '0;
            cnt <= '0;
            case (state)
              MUL_IDT: begin
                sat_seen <= sat_seen | idt_ovf | k_ovf;
                mcand    <= PW'($signed(e_cur));
                mplier   <= k_s;
                state    <= MUL_EK;
              end
              MUL_EK: begin
                ek_r     <= prod_s;
                sat_seen <= sat_seen | prod_ovf;
                mcand    <= PW'(e_prev[ch_r]);
                mplier   <= p_r;
                state    <= MUL_PE;
              end
              default: begin
                pe_r     <= prod_s;
                sat_seen <= sat_seen | prod_ovf;
                state    <= SUM;
              end
            endcase
          end
        end

        SUM: begin
          adj_r    <= adj_s;
          sat_seen <= sat_seen | adj_ovf;
          state    <= DONE;
        end

        DONE: begin
          // First DONE cycle publishes the result and commits the history;
          // afterwards the result is held until arm is released.
          if (!finished) begin
            adj_val        <= adj_r;
            dac_val        <= dac_s;
            clamped        <= sat_seen | dac_ovf;
            finished       <= 1'b1;
            busy           <= 1'b0;
            e_prev[ch_r]   <= e_cur;
            if (ANTI_WINDUP != 0)
              adj_prev[ch_r] <= {OUT_WHOLE'($signed(dac_s)), {OUT_FRAC{1'b0}}};
            else
              adj_prev[ch_r] <= adj_r;
          end else if (!arm) begin
            finished <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_loop_math_mc.sv
// Bench for control_loop_math_mc (default parameters: 4 channels, Q8.40
// constants, Q20.40 output, 20-bit DAC, anti-windup on). A reference model
// evaluates the update equation with wide plain arithmetic; a compare
// process checks every result when finished rises, and directed steps add
// hand-computed literal expectations.
module tb_control_loop_math_mc;

  localparam int          LATENCY = 3 * 48 + 2;
  localparam int          AW      = 1;
  localparam logic [47:0] ONE     = 48'h010000000000;
  localparam logic [47:0] TWO     = 48'h020000000000;
  localparam logic [47:0] HALF    = 48'h008000000000;
  localparam logic [47:0] HUNDRED = 48'h640000000000;
  localparam logic [47:0] NEG_LSB = 48'hFFFFFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_L, arm, clr;
  logic [1:0]  ch_sel;
  logic [17:0] setpt, measured;
  logic [47:0] cl_P, cl_I, dt;
  logic        busy, finished, clamped;
  logic [18:0] e_cur;
  logic [59:0] adj_val;
  logic [19:0] dac_val;

  control_loop_math_mc dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .arm      (arm),
    .ch_sel   (ch_sel),
    .clr      (clr),
    .setpt    (setpt),
    .measured (measured),
    .cl_P     (cl_P),
    .cl_I     (cl_I),
    .dt       (dt),
    .busy     (busy),
    .finished (finished),
    .e_cur    (e_cur),
    .adj_val  (adj_val),
    .dac_val  (dac_val),
    .clamped  (clamped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks    = 0;
  int failures  = 0;
  int fin_rises = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [18:0] e;
    logic [59:0] adj;
    logic [19:0] dac;
    logic        clamped;
    int          acc_cyc;
  } exp_t;

  exp_t                exp_q[$];
  logic signed [18:0]  m_eprev   [4];
  logic signed [59:0]  m_adjprev [4];

  function automatic logic signed [191:0] clampw(input logic signed [191:0] v,
                                                 input int w, inout bit ov);
    logic signed [191:0] hi, lo;
    hi = (192'sd1 <<< (w - 1)) - 192'sd1;
    lo = -hi - 192'sd1;
    if (v > hi) begin ov = 1'b1; return hi; end
    if (v < lo) begin ov = 1'b1; return lo; end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_eprev[i]   = '0;
      m_adjprev[i] = '0;
    end
  endtask

  task automatic model_update(input int ch, input logic [17:0] s, input logic [17:0] m,
                              input logic [47:0] p, input logic [47:0] i_c,
                              input logic [47:0] d, output exp_t r);
    logic signed [191:0] e, pv, iv, dv, ep, ap, idt, k, ek, pe, adj, whole, dac, stored;
    bit sat, dsat;
    sat  = 1'b0;
    dsat = 1'b0;
    e    = $signed(s) - $signed(m);
    pv   = $signed(p);
    iv   = $signed(i_c);
    dv   = $signed(d);
    ep   = m_eprev[ch];
    ap   = m_adjprev[ch];
    idt  = clampw((iv * dv) >>> 40, 48, sat);
    k    = clampw(pv + idt, 48, sat);
    ek   = clampw(k * e, 60, sat);
    pe   = clampw(pv * ep, 60, sat);
    adj  = clampw(ap + ek - pe, 60, sat);
    whole = adj >>> 40;
    dac  = clampw(whole, 20, dsat);
    r.e       = e[18:0];
    r.adj     = adj[59:0];
    r.dac     = dac[19:0];
    r.clamped = sat | dsat;
    r.acc_cyc = 0;
    stored = (AW != 0) ? (dac <<< 40) : adj;
    m_eprev[ch]   = e[18:0];
    m_adjprev[ch] = stored[59:0];
  endtask

  function automatic logic [59:0] fx(input int w);
    logic [19:0] t;
    t = w[19:0];
    return {t, 40'h0};
  endfunction

  // ---------------- compare process ----------------
  initial begin : compare
    logic fin_q;
    exp_t x;
    fin_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_L && finished && !fin_q) begin
        fin_rises++;
        if (exp_q.size() == 0) begin
          check("unexpected_finished", 1, 0);
        end else begin
          x = exp_q.pop_front();
          check("latency", cyc - x.acc_cyc, LATENCY);
          check("e_cur", e_cur, x.e);
          check("adj_val", adj_val, x.adj);
          check("dac_val", dac_val, x.dac);
          check("clamped", clamped, x.clamped);
          check("busy_at_finish", busy, 0);
        end
      end
      fin_q = rst_L ? finished : 1'b0;
    end
  end

  // ---------------- drivers ----------------
  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_finished"}, finished, 0);
    check({tag, "_e_cur"}, e_cur, 0);
    check({tag, "_adj_val"}, adj_val, 0);
    check({tag, "_dac_val"}, dac_val, 0);
    check({tag, "_clamped"}, clamped, 0);
  endtask

  task automatic do_update(input int ch, input int s, input int m,
                           input logic [47:0] p, input logic [47:0] i_c,
                           input logic [47:0] d, input bit clr_busy, input bit arm_drop);
    exp_t x;
    int   n;
    @(negedge clk);
    ch_sel   = ch[1:0];
    setpt    = s[17:0];
    measured = m[17:0];
    cl_P     = p;
    cl_I     = i_c;
    dt       = d;
    arm      = 1'b1;
    clr      = clr_busy;   // clr together with arm must be ignored
    @(posedge clk);
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    model_update(ch, setpt, measured, p, i_c, d, x);
    x.acc_cyc = cyc;
    exp_q.push_back(x);
    // Inputs are free to change once the update is accepted.
    setpt    = ~setpt;
    measured = 18'h15555;
    cl_P     = '1;
    cl_I     = '1;
    dt       = 48'h123456789ABC;
    if (clr_busy) ch_sel = 2'd3;
    else          ch_sel = ch_sel + 2'd1;
    if (arm_drop) arm = 1'b0;
    n = 0;
    while (!finished && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("finished_seen", finished, 1);
    clr = 1'b0;
    arm = 1'b0;
    @(negedge clk);
    check("finished_drop", finished, 0);
  endtask

  task automatic do_clr(input int ch);
    @(negedge clk);
    ch_sel = ch[1:0];
    clr    = 1'b1;
    arm    = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    m_eprev[ch]   = '0;
    m_adjprev[ch] = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int rises0;
    rst_L = 1'b0; arm = 1'b0; clr = 1'b0; ch_sel = '0;
    setpt = '0; measured = '0; cl_P = '0; cl_I = '0; dt = '0;
    model_reset();

    // T1 reset and idle
    repeat (3) @(negedge clk);
    check_reset("t1_reset");
    rst_L = 1'b1;
    repeat (20) @(negedge clk);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_finished", finished, 0);

    // T2 P-only path, then repeat with history
    do_update(0, 100, 0, ONE, '0, '0, 1'b0, 1'b0);
    check("t2_adj", adj_val, fx(100));
    check("t2_dac", dac_val, 20'd100);
    do_update(0, 100, 0, ONE, '0, '0, 1'b0, 1'b0);
    check("t2_adj_repeat", adj_val, fx(100));

    // T3 I-path, repeat, other channel (arm dropped mid-computation)
    do_update(2, 10, 0, '0, ONE, HALF, 1'b0, 1'b0);
    check("t3_adj_ch2", adj_val, fx(5));
    do_update(2, 10, 0, '0, ONE, HALF, 1'b0, 1'b0);
    check("t3_adj_ch2_repeat", adj_val, fx(10));
    do_update(1, 10, 0, '0, ONE, HALF, 1'b0, 1'b1);
    check("t3_adj_ch1", adj_val, fx(5));
    // idt = floor(0.5 * -2^-40) = -2^-40: arithmetic shift rounds toward -inf
    do_update(1, 1, 0, '0, HALF, NEG_LSB, 1'b0, 1'b0);
    check("t3_trunc_adj", adj_val, 60'h00004_FFFFFFFFFF);
    check("t3_trunc_dac", dac_val, 20'd4);
    // negative result on ch2: 10 - 40 - 10
    do_update(2, 0, 40, ONE, '0, '0, 1'b0, 1'b0);
    check("t3_neg_adj", adj_val, 60'hFFFD8_0000000000);
    check("t3_neg_dac", dac_val, 20'hFFFD8);

    // T4 saturation, then anti-windup history
    do_update(3, 131071, -131072, HUNDRED, '0, '0, 1'b0, 1'b0);
    check("t4_e_cur", e_cur, 19'h3FFFF);
    check("t4_adj_max", adj_val, 60'h7FFFF_FFFFFFFFFF);
    check("t4_dac", dac_val, 20'd524287);
    check("t4_clamped", clamped, 1);
    do_update(3, 0, 0, '0, '0, '0, 1'b0, 1'b0);
    check("t4_aw_adj", adj_val, fx(524287));
    check("t4_aw_clamped", clamped, 0);

    // T5 reset in the middle of an update
    rises0 = fin_rises;
    @(negedge clk);
    ch_sel = 2'd0; setpt = 18'd100; measured = '0;
    cl_P = ONE; cl_I = '0; dt = '0; arm = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_busy", busy, 1);
    repeat (49) @(negedge clk);
    rst_L = 1'b0;
    #1;
    check_reset("t5_reset");
    arm = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_L = 1'b1;
    repeat (160) @(negedge clk);
    check("t5_no_finish", fin_rises - rises0, 0);
    // zero history: 2*50 = 100 (stale history would give 0)
    do_update(0, 50, 0, TWO, '0, '0, 1'b0, 1'b0);
    check("t5_fresh_adj", adj_val, fx(100));

    // T6 clr behaviour
    do_update(3, 20, 0, ONE, '0, '0, 1'b0, 1'b0);
    check("t6_build", adj_val, fx(20));
    do_clr(3);
    do_update(3, 20, 0, TWO, '0, '0, 1'b0, 1'b0);
    check("t6_after_clr", adj_val, fx(40));
    // clr held while busy (ch_sel=3) and together with arm: both ignored
    do_update(0, 5, 0, ONE, '0, '0, 1'b1, 1'b0);
    check("t6_clr_busy_ch0", adj_val, fx(55));
    do_update(3, 10, 0, ONE, '0, '0, 1'b0, 1'b0);
    check("t6_history_kept", adj_val, fx(30));

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
